// File: rtl/imem_line_fill.sv
// rtl/imem_line_fill.sv - instruction-cache line refill responder
//
// Purpose: accepts a line refill request, streams LINE_WORDS consecutive
// 32-bit reads out of a pipelined backing-memory port (at most
// MAX_OUTSTANDING in flight), assembles them into one line register and
// holds the line on axi_rd_* until the cache's ack pulse (from another
// clock domain) is seen. One request arriving while busy is remembered in
// a single pending slot; the newest such request wins.
//
// Ports:
//   axi_clk, i_rst            clock, synchronous active-high reset
//   axi_rd_rq, axi_rd_addr    refill request pulse and address
//   axi_rd_valid(_addr/_data) delivered line, its aligned base and contents
//   axi_rd_valid_ack          asynchronous ack pulse, synchronized here
//   mem_req/mem_addr/mem_gnt  backing read request channel
//   mem_rvalid/mem_rdata      in-order read return channel
//   busy                      high whenever a fill or delivery is active
//
// Optional build macro IMEM_LINE_FILL_ERR_EN adds mem_rerr (read error,
// qualified by mem_rvalid) and fill_err (one-cycle pulse in place of a
// delivery when any word of the fill returned an error).
`timescale 1ns/1ps

module imem_line_fill #(
  parameter int LINE_WORDS      = 1024,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     axi_clk,
  input  logic                     i_rst,
  input  logic                     axi_rd_rq,
  input  logic [31:0]              axi_rd_addr,
  output logic                     axi_rd_valid,
  output logic [31:0]              axi_rd_valid_addr,
  output logic [LINE_WORDS*32-1:0] axi_rd_data,
  input  logic                     axi_rd_valid_ack,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
`ifdef IMEM_LINE_FILL_ERR_EN
  input  logic                     mem_rerr,
  output logic                     fill_err,
`endif
  output logic                     busy
);

  localparam int IW = $clog2(LINE_WORDS);
  localparam int CW = IW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int L  = $clog2(LINE_WORDS * 4);
  localparam logic [CW-1:0] LW_C = CW'(LINE_WORDS);
  localparam logic [OW-1:0] MO_C = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DELIVER
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             base_q, base_d;
  logic [CW-1:0]           issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]           ret_cnt_q, ret_cnt_d;
  logic [OW-1:0]           out_cnt_q, out_cnt_d;
  logic [LINE_WORDS*32-1:0] line_q, line_d;
  logic                    valid_q, valid_d;
  logic [31:0]             vaddr_q, vaddr_d;
  logic                    pend_v_q, pend_v_d;
  logic [31:0]             pend_base_q, pend_base_d;
  logic                    ack_s1_q, ack_s1_d;
  logic                    ack_s2_q, ack_s2_d;
  logic                    ack_s3_q, ack_s3_d;
`ifdef IMEM_LINE_FILL_ERR_EN
  logic                    err_q, err_d;
  logic                    fill_err_q, fill_err_d;
`endif

  logic [31:0] rq_base;
  logic        issue_fire;
  logic        ret_fire;
  logic        ack_rise;
  logic        fill_bad;
  logic        unused_addr_bits;

  assign rq_base          = {axi_rd_addr[31:L], {L{1'b0}}};
  assign unused_addr_bits = ^axi_rd_addr[L-1:0];

  assign mem_req    = (state_q == ST_FETCH) && (issue_cnt_q < LW_C) && (out_cnt_q < MO_C);
  assign mem_addr   = base_q + (32'(issue_cnt_q) << 2);
  assign issue_fire = mem_req && mem_gnt;
  assign ret_fire   = (state_q == ST_FETCH) && mem_rvalid;
  // ack_s1/ack_s2 are the synchronizer; ack_s3 only remembers the previous
  // synchronized level for edge detection.
  assign ack_rise   = ack_s2_q && !ack_s3_q;

`ifdef IMEM_LINE_FILL_ERR_EN
  assign fill_bad = err_q;
  assign fill_err = fill_err_q;
`else
  assign fill_bad = 1'b0;
`endif

  assign axi_rd_valid      = valid_q;
  assign axi_rd_valid_addr = vaddr_q;
  assign axi_rd_data       = line_q;
  assign busy              = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    out_cnt_d   = out_cnt_q;
    line_d      = line_q;
    valid_d     = valid_q;
    vaddr_d     = vaddr_q;
    pend_v_d    = pend_v_q;
    pend_base_d = pend_base_q;
    ack_s1_d    = axi_rd_valid_ack;
    ack_s2_d    = ack_s1_q;
    ack_s3_d    = ack_s2_q;
`ifdef IMEM_LINE_FILL_ERR_EN
    err_d       = err_q;
    fill_err_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pend_v_q || axi_rd_rq) begin
          // The pending slot is older than a simultaneous request, so it
          // is served first and the new request takes its place.
          state_d     = ST_FETCH;
          base_d      = pend_v_q ? pend_base_q : rq_base;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          out_cnt_d   = '0;
`ifdef IMEM_LINE_FILL_ERR_EN
          err_d       = 1'b0;
`endif
          pend_v_d    = 1'b0;
          if (pend_v_q && axi_rd_rq && (rq_base != pend_base_q)) begin
            pend_v_d    = 1'b1;
            pend_base_d = rq_base;
          end
        end
      end

      ST_FETCH: begin
        if (issue_fire) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        out_cnt_d = out_cnt_q + OW'(issue_fire) - OW'(ret_fire);
        if (ret_fire && (ret_cnt_q < LW_C)) begin
          line_d[{ret_cnt_q[IW-1:0], 5'b0} +: 32] = mem_rdata;
          ret_cnt_d = ret_cnt_q + 1'b1;
`ifdef IMEM_LINE_FILL_ERR_EN
          if (mem_rerr) begin
            err_d = 1'b1;
          end
`endif
        end
        // Completion is judged from the registered return count, one edge
        // after the last word lands, so mem_rvalid never reaches
        // axi_rd_valid combinationally.
        if (ret_cnt_q == LW_C) begin
          if (fill_bad) begin
            state_d = ST_IDLE;
`ifdef IMEM_LINE_FILL_ERR_EN
            fill_err_d = 1'b1;
            err_d      = 1'b0;
`endif
          end else begin
            state_d = ST_DELIVER;
            valid_d = 1'b1;
            vaddr_d = base_q;
          end
        end
      end

      ST_DELIVER: begin
        if (ack_rise) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // While busy, remember only the newest request for a different line.
    if ((state_q != ST_IDLE) && axi_rd_rq && (rq_base != base_q)) begin
      pend_v_d    = 1'b1;
      pend_base_d = rq_base;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      out_cnt_q   <= '0;
      line_q      <= '0;
      valid_q     <= 1'b0;
      vaddr_q     <= '0;
      pend_v_q    <= 1'b0;
      pend_base_q <= '0;
      ack_s1_q    <= 1'b0;
      ack_s2_q    <= 1'b0;
      ack_s3_q    <= 1'b0;
`ifdef IMEM_LINE_FILL_ERR_EN
      err_q       <= 1'b0;
      fill_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      out_cnt_q   <= out_cnt_d;
      line_q      <= line_d;
      valid_q     <= valid_d;
      vaddr_q     <= vaddr_d;
      pend_v_q    <= pend_v_d;
      pend_base_q <= pend_base_d;
      ack_s1_q    <= ack_s1_d;
      ack_s2_q    <= ack_s2_d;
      ack_s3_q    <= ack_s3_d;
`ifdef IMEM_LINE_FILL_ERR_EN
      err_q       <= err_d;
      fill_err_q  <= fill_err_d;
`endif
    end
  end

  // A return with nothing outstanding means the memory broke the protocol.
  a_no_orphan_rvalid: assert property (
    @(posedge axi_clk) disable iff (i_rst) !(mem_rvalid && (out_cnt_q == '0))
  );

endmodule

// File: tb/tb_imem_line_fill.sv
// tb/tb_imem_line_fill.sv - self-checking bench for imem_line_fill
`timescale 1ns/1ps

module tb_imem_line_fill;

  localparam int LW  = 8;
  localparam int MAX = 2;

  logic          axi_clk;
  logic          i_rst;
  logic          axi_rd_rq;
  logic [31:0]   axi_rd_addr;
  logic          axi_rd_valid;
  logic [31:0]   axi_rd_valid_addr;
  logic [LW*32-1:0] axi_rd_data;
  logic          axi_rd_valid_ack;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          busy;
`ifdef IMEM_LINE_FILL_ERR_EN
  logic          mem_rerr;
  logic          fill_err;
  int            err_word;
  int            k_ret;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat;
  bit gnt_rand;
  bit no_valid;
  logic [31:0] exp_base;
  int k_iss;
  int ret_total;
  logic [31:0] fill_base;
  logic [31:0] first_addr;
  logic [31:0] last_addr;
  logic [31:0] fetched[$];
  logic [31:0] exp_fetch[$];
  logic [31:0] addr_q[$];
  int          due_q[$];

  imem_line_fill #(.LINE_WORDS(LW), .MAX_OUTSTANDING(MAX)) dut (
    .axi_clk          (axi_clk),
    .i_rst            (i_rst),
    .axi_rd_rq        (axi_rd_rq),
    .axi_rd_addr      (axi_rd_addr),
    .axi_rd_valid     (axi_rd_valid),
    .axi_rd_valid_addr(axi_rd_valid_addr),
    .axi_rd_data      (axi_rd_data),
    .axi_rd_valid_ack (axi_rd_valid_ack),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_gnt          (mem_gnt),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
`ifdef IMEM_LINE_FILL_ERR_EN
    .mem_rerr         (mem_rerr),
    .fill_err         (fill_err),
`endif
    .busy             (busy)
  );

  initial begin
    axi_clk = 1'b0;
    forever #5 axi_clk = ~axi_clk;
  end

  initial forever begin
    @(posedge axi_clk);
    cyc++;
  end

  // Backing memory contents: every word encodes its own byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Backing memory: grants decided each cycle, returns in order after lat cycles.
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hBAD0BAD0;
    k_iss = 0; ret_total = 0; fill_base = '0; first_addr = '0; last_addr = '0;
`ifdef IMEM_LINE_FILL_ERR_EN
    mem_rerr = 1'b0; k_ret = 0;
`endif
    forever begin
      @(negedge axi_clk);
      if (i_rst) begin
        addr_q.delete(); due_q.delete();
        mem_rvalid = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'hBAD0BAD0;
        k_iss = 0;
`ifdef IMEM_LINE_FILL_ERR_EN
        mem_rerr = 1'b0; k_ret = 0;
`endif
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hBAD0BAD0;
`ifdef IMEM_LINE_FILL_ERR_EN
        mem_rerr = 1'b0;
`endif
        if (addr_q.size() > 0 && due_q[0] <= cyc) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(addr_q[0]);
`ifdef IMEM_LINE_FILL_ERR_EN
          mem_rerr = (k_ret == err_word);
          k_ret = (k_ret + 1) % LW;
`endif
          void'(addr_q.pop_front());
          void'(due_q.pop_front());
          ret_total++;
        end
        mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mem_req && mem_gnt) begin
          if (k_iss == 0) begin
            fill_base  = mem_addr;
            first_addr = mem_addr;
            fetched.push_back(mem_addr);
            chk("fill_base_aligned", {27'd0, mem_addr[4:0]}, 32'd0);
          end
          chk("mem_addr_seq", mem_addr, fill_base + 32'(4 * k_iss));
          if (k_iss == LW - 1) last_addr = mem_addr;
          addr_q.push_back(mem_addr);
          due_q.push_back(cyc + lat);
          chk("inflight_max", 32'(addr_q.size() + int'(mem_rvalid) > MAX), 32'd0);
          k_iss = (k_iss + 1) % LW;
        end
      end
    end
  end

  // Per-cycle check of the delivered line against the memory contents.
  initial forever begin
    logic [LW*32-1:0] e;
    @(negedge axi_clk);
    if (!i_rst && axi_rd_valid) begin
      if (no_valid) chk("valid_after_err", 32'd1, 32'd0);
      chk("valid_addr", axi_rd_valid_addr, exp_base);
      for (int i = 0; i < LW; i++) e[i*32 +: 32] = mem_word(exp_base + 32'(4 * i));
      total++;
      if (axi_rd_data !== e) begin
        bad++;
        $display("FAIL line_data act=%h exp=%h", axi_rd_data, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  // Request sampled at the first posedge inside the task ("edge 0").
  task automatic send_rq(input logic [31:0] a);
    @(negedge axi_clk); #1;
    axi_rd_rq = 1'b1; axi_rd_addr = a;
    @(posedge axi_clk); #1;
    axi_rd_rq = 1'b0; axi_rd_addr = 32'hFFFF_FFFF;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (n < max) begin
      @(posedge axi_clk); #1;
      n++;
      if (axi_rd_valid) break;
    end
    if (!axi_rd_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_ack(input int phase, input string name);
    int n;
    @(posedge axi_clk); #(phase);
    axi_rd_valid_ack = 1'b1;
    n = 0;
    while (n < 8) begin
      @(posedge axi_clk); #1;
      n++;
      if (n == 2) axi_rd_valid_ack = 1'b0;
      if (!axi_rd_valid) break;
    end
    axi_rd_valid_ack = 1'b0;
    chk(name, 32'(n >= 3 && n <= 4), 32'd1);
  endtask

  initial begin
    int n;
    i_rst = 1'b1; axi_rd_rq = 1'b0; axi_rd_addr = '0; axi_rd_valid_ack = 1'b0;
    lat = 1; gnt_rand = 1'b0; no_valid = 1'b0; exp_base = '0;
`ifdef IMEM_LINE_FILL_ERR_EN
    err_word = -1;
`endif
    repeat (3) @(posedge axi_clk); #1;
    chk("rst_valid", {31'd0, axi_rd_valid}, 32'd0);
    chk("rst_valid_addr", axi_rd_valid_addr, 32'd0);
    chk("rst_data", 32'(axi_rd_data != '0), 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge axi_clk); #1;
    i_rst = 1'b0;

    // Zero-wait fill: latency, addresses and literal words.
    exp_base = 32'h1220; exp_fetch.push_back(32'h1220);
    send_rq(32'h0000_1234);
    wait_valid(40, n);
    chk("latency", 32'(n), 32'd10);
    chk("t1_valid_addr", axi_rd_valid_addr, 32'h0000_1220);
    chk("t1_word0", axi_rd_data[31:0], 32'hEDDF_1220);
    chk("t1_word7", axi_rd_data[255:224], 32'hEDC3_123C);
    chk("t1_first_addr", first_addr, 32'h0000_1220);
    chk("t1_last_addr", last_addr, 32'h0000_123C);
    repeat (5) @(posedge axi_clk); #1;
    chk("t1_valid_held", {31'd0, axi_rd_valid}, 32'd1);
    do_ack(3, "t1_ack_drop");
    chk("t1_idle_after_ack", {31'd0, busy}, 32'd0);

    // A stray ack while idle must do nothing.
    @(posedge axi_clk); #6;
    axi_rd_valid_ack = 1'b1;
    repeat (2) @(posedge axi_clk); #1;
    axi_rd_valid_ack = 1'b0;
    repeat (6) @(posedge axi_clk); #1;
    chk("idle_ack_busy", {31'd0, busy}, 32'd0);
    chk("idle_ack_valid", {31'd0, axi_rd_valid}, 32'd0);
    chk("idle_ack_req", {31'd0, mem_req}, 32'd0);

    // Stalled grants, latency 3: in-flight bound checked by the memory model.
    lat = 3; gnt_rand = 1'b1;
    exp_base = 32'h2000; exp_fetch.push_back(32'h2000);
    send_rq(32'h0000_2010);
    wait_valid(300, n);
    do_ack(7, "t2_ack_drop");

    // Pending slot: newest wins, same-line request dropped.
    lat = 1; gnt_rand = 1'b0;
    exp_base = 32'h0000; exp_fetch.push_back(32'h0000); exp_fetch.push_back(32'h8000);
    send_rq(32'h0000_0000);
    repeat (2) @(posedge axi_clk);
    send_rq(32'h0000_4000);
    send_rq(32'h0000_8004);
    send_rq(32'h0000_0010);
    wait_valid(40, n);
    do_ack(5, "t3_ack_drop_a");
    exp_base = 32'h8000;
    wait_valid(40, n);
    chk("t3_pending_addr", axi_rd_valid_addr, 32'h0000_8000);
    do_ack(2, "t3_ack_drop_b");
    repeat (5) @(posedge axi_clk); #1;
    chk("t3_no_more_fill", {31'd0, busy}, 32'd0);

    // Reset in the middle of a fill.
    exp_base = 32'h3000; exp_fetch.push_back(32'h3000);
    send_rq(32'h0000_3000);
    n = 0;
    while (k_iss != 5 && n < 40) begin
      @(negedge axi_clk); #1;
      n++;
    end
    chk("t4_reached_issue5", 32'(k_iss), 32'd5);
    @(posedge axi_clk); #1;
    i_rst = 1'b1;
    @(posedge axi_clk); #1;
    chk("t4_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t4_rst_busy", {31'd0, busy}, 32'd0);
    chk("t4_rst_valid", {31'd0, axi_rd_valid}, 32'd0);
    @(negedge axi_clk); #1;
    i_rst = 1'b0;
    lat = 2; gnt_rand = 1'b1;
    exp_base = 32'h5000; exp_fetch.push_back(32'h5000);
    send_rq(32'h0000_5010);
    wait_valid(300, n);
    do_ack(4, "t4_ack_drop");

`ifdef IMEM_LINE_FILL_ERR_EN
    begin
      int pulses;
      int ret0;
      lat = 1; gnt_rand = 1'b0; err_word = 3; no_valid = 1'b1;
      exp_base = 32'h6000; exp_fetch.push_back(32'h6000);
      ret0 = ret_total;
      pulses = 0;
      send_rq(32'h0000_6000);
      repeat (30) begin
        @(posedge axi_clk); #1;
        if (fill_err) pulses++;
      end
      chk("t5_drained", 32'(ret_total - ret0), 32'd8);
      chk("t5_err_pulses", 32'(pulses), 32'd1);
      chk("t5_idle", {31'd0, busy}, 32'd0);
      chk("t5_no_valid", {31'd0, axi_rd_valid}, 32'd0);
      err_word = -1; no_valid = 1'b0;
      exp_base = 32'h7000; exp_fetch.push_back(32'h7000);
      send_rq(32'h0000_7000);
      wait_valid(40, n);
      chk("t5_next_valid", {31'd0, axi_rd_valid}, 32'd1);
      do_ack(6, "t5_ack_drop");
    end
`endif

    chk("fetch_count", 32'(fetched.size()), 32'(exp_fetch.size()));
    for (int i = 0; i < exp_fetch.size(); i++) begin
      if (i < fetched.size()) chk("fetch_base", fetched[i], exp_fetch[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
